// File: rtl/demultiplexador1x2_fila_pkg.sv
// -----------------------------------------------------------------------------
// demultiplexador1x2_fila_pkg
//
// Shared definitions for the registered 1-to-2 demultiplexer and its
// per-output FIFOs.
//
//   LARGURA_PADRAO       default data word width in bits
//   PROFUNDIDADE_PADRAO  default entries per output FIFO (power of 2, >= 2)
//   CONTADOR_LARGURA     width of the optional per-output push counters
//   destino_e            decoded meaning of the M select bit
// -----------------------------------------------------------------------------
package demultiplexador1x2_fila_pkg;

    localparam int LARGURA_PADRAO      = 16;
    localparam int PROFUNDIDADE_PADRAO = 2;
    localparam int CONTADOR_LARGURA    = 16;

    // Destination chosen by M: 0 routes to output 0, 1 routes to output 1.
    typedef enum logic {
        DESTINO_SAIDA0 = 1'b0,
        DESTINO_SAIDA1 = 1'b1
    } destino_e;

endpackage : demultiplexador1x2_fila_pkg

// File: rtl/demultiplexador1x2_fila_fila_sincrona.sv
// -----------------------------------------------------------------------------
// fila_sincrona
//
// Single-clock FIFO with a combinational head view. Occupancy is kept in a
// log2(PROFUNDIDADE)+1 bit count so full and empty never alias; the read and
// write pointers wrap naturally modulo PROFUNDIDADE.
//
// Ports:
//   clock   in   rising-edge clock
//   reset   in   asynchronous, active-high reset (clears pointers and storage)
//   push    in   write dado this edge (ignored while cheia)
//   dado    in   word to write
//   pop     in   remove the head this edge (ignored while vazia)
//   cabeca  out  current head entry (0 after reset while empty)
//   cheia   out  FIFO holds PROFUNDIDADE words
//   vazia   out  FIFO holds no words
// -----------------------------------------------------------------------------
module fila_sincrona
    import demultiplexador1x2_fila_pkg::*;
#(
    parameter int LARGURA      = LARGURA_PADRAO,
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [LARGURA-1:0] dado,
    input  logic               pop,
    output logic [LARGURA-1:0] cabeca,
    output logic               cheia,
    output logic               vazia
);

    localparam int PTR_W = $clog2(PROFUNDIDADE);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] OCUP_CHEIA = CNT_W'(PROFUNDIDADE);

    logic [LARGURA-1:0] mem_q [PROFUNDIDADE];
    logic [LARGURA-1:0] mem_d [PROFUNDIDADE];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   ocup_q, ocup_d;

    logic push_ok;
    logic pop_ok;

    assign cheia   = (ocup_q == OCUP_CHEIA);
    assign vazia   = (ocup_q == '0);
    assign push_ok = push && !cheia;
    assign pop_ok  = pop && !vazia;
    assign cabeca  = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every signal written here gets its hold value first, so no
        // path through the block leaves it unassigned and no latch is inferred.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ocup_d   = ocup_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = dado;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Simultaneous push and pop leaves the occupancy unchanged.
        unique case ({push_ok, pop_ok})
            2'b10:   ocup_d = ocup_q + CNT_W'(1);
            2'b01:   ocup_d = ocup_q - CNT_W'(1);
            default: ocup_d = ocup_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the storage is reset on purpose: the head must read 0
            // after reset, and at this depth the cost is a handful of flops.
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ocup_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments for all state, so every flop
            // samples the pre-edge values computed in the always_comb above.
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ocup_q   <= ocup_d;
        end
    end

endmodule : fila_sincrona

// File: rtl/demultiplexador1x2_fila.sv
// -----------------------------------------------------------------------------
// demultiplexador1x2_fila
//
// Registered 1-to-2 demultiplexer for LARGURA-bit words. Each accepted word
// is pushed into the FIFO selected by M; each output drains its own FIFO
// through a valid/ready handshake, so a stalled consumer never blocks the
// other one. There is no combinational path from entrada to saida0/saida1.
//
// Ports:
//   clock           in   rising-edge clock
//   reset           in   asynchronous, active-high reset
//   entrada         in   input data word
//   entrada_valida  in   entrada and M are valid this cycle
//   M               in   destination select (0 -> output 0, 1 -> output 1)
//   entrada_pronta  out  FIFO[M] can accept a word (depends on M only)
//   saida0/1        out  head word of FIFO 0/1
//   valida0/1       out  saida0/1 holds a valid word
//   pronta0/1       in   consumer 0/1 takes saida0/1 this cycle
//   contador0/1     out  words pushed to FIFO 0/1 since reset, wrapping
//                        (only when DEMUX_CONTADORES_EN is defined)
//
// Build option: define DEMUX_CONTADORES_EN to add the push counters.
// -----------------------------------------------------------------------------
module demultiplexador1x2_fila
    import demultiplexador1x2_fila_pkg::*;
#(
    parameter int LARGURA      = LARGURA_PADRAO,
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [LARGURA-1:0]          entrada,
    input  logic                        entrada_valida,
    input  logic                        M,
    output logic                        entrada_pronta,
    output logic [LARGURA-1:0]          saida0,
    output logic                        valida0,
    input  logic                        pronta0,
    output logic [LARGURA-1:0]          saida1,
    output logic                        valida1,
    input  logic                        pronta1
`ifdef DEMUX_CONTADORES_EN
    ,
    output logic [CONTADOR_LARGURA-1:0] contador0,
    output logic [CONTADOR_LARGURA-1:0] contador1
`endif
);

    destino_e destino;
    logic     cheia0, cheia1;
    logic     vazia0, vazia1;
    logic     push0, push1;
    logic     pop0, pop1;
    logic     aceita;

    assign destino = destino_e'(M);

    // Ready looks only at the selected FIFO's full flag. A full FIFO stays
    // not-ready even while it is being popped: no same-cycle pass-through.
    always_comb begin
        entrada_pronta = 1'b0;
        if (!reset) begin
            unique case (destino)
                DESTINO_SAIDA0: entrada_pronta = !cheia0;
                DESTINO_SAIDA1: entrada_pronta = !cheia1;
                default:        entrada_pronta = 1'b0;
            endcase
        end
    end

    assign aceita = entrada_valida && entrada_pronta;
    assign push0  = aceita && (destino == DESTINO_SAIDA0);
    assign push1  = aceita && (destino == DESTINO_SAIDA1);

    assign valida0 = !vazia0;
    assign valida1 = !vazia1;
    assign pop0    = valida0 && pronta0;
    assign pop1    = valida1 && pronta1;

    fila_sincrona #(
        .LARGURA      (LARGURA),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_fila0 (
        .clock  (clock),
        .reset  (reset),
        .push   (push0),
        .dado   (entrada),
        .pop    (pop0),
        .cabeca (saida0),
        .cheia  (cheia0),
        .vazia  (vazia0)
    );

    fila_sincrona #(
        .LARGURA      (LARGURA),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_fila1 (
        .clock  (clock),
        .reset  (reset),
        .push   (push1),
        .dado   (entrada),
        .pop    (pop1),
        .cabeca (saida1),
        .cheia  (cheia1),
        .vazia  (vazia1)
    );

`ifdef DEMUX_CONTADORES_EN
    logic [CONTADOR_LARGURA-1:0] contador0_q, contador0_d;
    logic [CONTADOR_LARGURA-1:0] contador1_q, contador1_d;

    // Counters wrap from all-ones back to 0 by plain modular addition.
    always_comb begin
        contador0_d = contador0_q;
        contador1_d = contador1_q;
        if (push0) begin
            contador0_d = contador0_q + CONTADOR_LARGURA'(1);
        end
        if (push1) begin
            contador1_d = contador1_q + CONTADOR_LARGURA'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contador0_q <= '0;
            contador1_q <= '0;
        end else begin
            contador0_q <= contador0_d;
            contador1_q <= contador1_d;
        end
    end

    assign contador0 = contador0_q;
    assign contador1 = contador1_q;
`else
    // Push counters are not part of this build.
`endif

endmodule : demultiplexador1x2_fila
